mmc_game_ctrl: RTL

//  Drives the control side of multi_mode_counter: issues start/reload loads, holds the count mode,

---
 rtl/mmc_pkg.sv | 32 +++
 rtl/mmc_tally.sv | 22 ++
 rtl/mmc_game_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mmc_pkg.sv
// rtl/mmc_pkg.sv - shared states, mode/who codes and verdict helper for the counter controller
package mmc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        RELOAD = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_UP1 = 2'b00;
    localparam logic [1:0] MODE_UP2 = 2'b01;
    localparam logic [1:0] MODE_DN1 = 2'b10;
    localparam logic [1:0] MODE_DN2 = 2'b11;

    localparam logic [1:0] WHO_NONE   = 2'b00;
    localparam logic [1:0] WHO_LOSER  = 2'b01;
    localparam logic [1:0] WHO_WINNER = 2'b10;

    localparam logic [3:0] TALLY_MAX = 4'hF;

    // A verdict is only believable if the side it names reached a full tally.
    function automatic logic verdict_bad(input logic [1:0] res,
                                         input logic [3:0] win,
                                         input logic [3:0] lose);
        return (res == WHO_WINNER && win != TALLY_MAX) ||
               (res == WHO_LOSER && lose != TALLY_MAX) ||
               (res == WHO_NONE);
    endfunction

endpackage

// File: rtl/mmc_tally.sv
// rtl/mmc_tally.sv - 4-bit saturating event tally with synchronous clear
module mmc_tally
    import mmc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && count != TALLY_MAX) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/mmc_game_ctrl.sv
// rtl/mmc_game_ctrl.sv - control FSM for multi_mode_counter; RUN watchdog under MMC_CTRL_TIMEOUT_EN
module mmc_game_ctrl
    import mmc_pkg::*;
#(
    parameter int W             = 4,
    parameter int FLIP_ON_EVENT = 0,
    parameter int TIMEOUT_CYC   = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [1:0]   mode_cfg,
    input  logic [W-1:0] seed,
    input  logic         reload_en,
    input  logic         winner,
    input  logic         loser,
    input  logic         game_over,
    input  logic [1:0]   who,
    output logic [1:0]   control,
    output logic         init,
    output logic [W-1:0] load_data,
    output logic         busy,
    output logic         done,
    output logic [1:0]   result,
    output logic [3:0]   win_tally,
    output logic [3:0]   lose_tally,
    output logic         mismatch
`ifdef MMC_CTRL_TIMEOUT_EN
    ,
    output logic         timeout_pulse
`endif
);

    state_t       state_q, state_d;
    logic [1:0]   mode_q;
    logic [W-1:0] seed_q;
    logic         reload_q;
    logic [1:0]   result_q;
    logic         mismatch_q;
    logic         check_q;

    logic accept_start, in_run, run_evt, timeout_hit;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("mmc_game_ctrl: TIMEOUT_CYC must be at least 1");
    end

    assign accept_start = start && !abort && (state_q == IDLE || state_q == DONE);
    assign in_run       = (state_q == RUN);
    assign run_evt      = in_run && !abort && (winner || loser);

`ifdef MMC_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;

    assign timeout_hit   = in_run && (wd_q == WD_W'(TIMEOUT_CYC));
    assign timeout_pulse = timeout_hit;

    // Only quiet RUN cycles advance the watchdog; LOAD/RELOAD/IDLE/DONE all clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (!in_run || run_evt || timeout_hit) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = LOAD;
                LOAD:    state_d = RUN;
                RUN: begin
                    if (game_over) begin
                        state_d = DONE;
                    end else if (((winner || loser) && reload_q) || timeout_hit) begin
                        state_d = RELOAD;
                    end
                end
                RELOAD:  state_d = RUN;
                DONE:    if (start) state_d = LOAD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= 2'b00;
            seed_q     <= '0;
            reload_q   <= 1'b0;
            result_q   <= WHO_NONE;
            mismatch_q <= 1'b0;
            check_q    <= 1'b0;
        end else begin
            check_q <= 1'b0;
            if (accept_start) begin
                mode_q     <= mode_cfg;
                seed_q     <= seed;
                reload_q   <= reload_en;
                result_q   <= WHO_NONE;
                mismatch_q <= 1'b0;
            end else begin
                if (FLIP_ON_EVENT != 0 && run_evt) begin
                    mode_q[1] <= ~mode_q[1];
                end
                if (in_run && !abort && winner && loser) begin
                    mismatch_q <= 1'b1;
                end
                if (in_run && !abort && game_over) begin
                    result_q <= who;
                    check_q  <= 1'b1;
                end
                // Tallies absorb any event coincident with game_over one edge later.
                if (check_q && verdict_bad(result_q, win_tally, lose_tally)) begin
                    mismatch_q <= 1'b1;
                end
            end
        end
    end

    mmc_tally u_win_tally (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_start),
        .inc   (in_run && !abort && winner),
        .count (win_tally)
    );

    mmc_tally u_lose_tally (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_start),
        .inc   (in_run && !abort && loser),
        .count (lose_tally)
    );

    assign control   = mode_q;
    assign load_data = seed_q;
    assign init      = (state_q == LOAD) || (state_q == RELOAD);
    assign busy      = (state_q == LOAD) || (state_q == RUN) || (state_q == RELOAD);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign mismatch  = mismatch_q;

endmodule
